// File: rtl/traffic_sensor_cond_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | traffic_sensor_cond_if                                                 |
// | Raw sensor inputs and conditioned controller outputs of the sensor     |
// | conditioning stage.                                                    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface traffic_sensor_cond_if;
  logic i_sens_a;
  logic i_sens_b;
  logic i_ped_btn;
  logic o_TA;
  logic o_TB;
  logic o_P;
  logic o_R;
  logic o_busy;

  modport master (
    output i_sens_a, i_sens_b, i_ped_btn,
    input  o_TA, o_TB, o_P, o_R, o_busy
  );

  modport slave (
    input  i_sens_a, i_sens_b, i_ped_btn,
    output o_TA, o_TB, o_P, o_R, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/traffic_sensor_cond.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | traffic_sensor_cond                                                    |
// | Synchronise/debounce road sensors and push-button; drive TA/TB with a  |
// | minimum hold and P/R pulses from a timed parade sequencer.             |
// | Optional: define PED_QUEUE_EN to queue one press made during a parade. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module traffic_sensor_cond #(
  parameter int DEB_CYCLES    = 4,
  parameter int HOLD_CYCLES   = 8,
  parameter int PARADE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  traffic_sensor_cond_if.slave bus
);

  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_hold     = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] c_parade   = CNT_W'(PARADE_CYCLES);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  logic [2:0] w_raw;
  logic [2:0] w_deb;
  logic [1:0] w_traffic;

  // Channel order: 0 = road A, 1 = road B, 2 = pedestrian button
  assign w_raw = {bus.i_ped_btn, bus.i_sens_b, bus.i_sens_a};

  generate
    for (genvar g = 0; g < 3; g++) begin : g_ch
      logic             r_s1;
      logic             r_s2;
      logic             r_deb;
      logic [CNT_W-1:0] r_cnt;
      logic             w_flip;

      assign w_flip = (r_s2 != r_deb) && (r_cnt == c_deb_last);

      always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_deb <= 1'b0;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_raw[g];
          r_s2 <= r_s1;
          if (r_s2 == r_deb) begin
            r_cnt <= '0;
          end else if (w_flip) begin
            r_deb <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end
      end

      assign w_deb[g] = r_deb;

      // Road channels stretch their falling edge by the hold time
      if (g < 2) begin : g_hold
        logic [CNT_W-1:0] r_hold;

        always_ff @(posedge i_clk) begin
          if (!i_rstn) begin
            r_hold <= '0;
          end else if (w_flip && r_deb) begin
            r_hold <= c_hold;
          end else if (w_flip) begin
            r_hold <= '0;
          end else if (!r_deb && (r_hold != '0)) begin
            r_hold <= r_hold - c_one;
          end
        end

        assign w_traffic[g] = r_deb | (r_hold != '0);
      end
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_PARADE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] w_pcnt_nxt;
  logic             r_btn_q;
  logic             w_btn_rise;
  logic             w_p;
  logic             w_r;
  logic             w_busy;
`ifdef PED_QUEUE_EN
  logic             r_pend;
  logic             w_pend_nxt;
`endif

  assign w_btn_rise = w_deb[2] & ~r_btn_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      r_pcnt  <= '0;
      r_btn_q <= 1'b0;
`ifdef PED_QUEUE_EN
      r_pend  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_btn_q <= w_deb[2];
`ifdef PED_QUEUE_EN
      r_pend  <= w_pend_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_p         = 1'b0;
    w_r         = 1'b0;
    w_busy      = 1'b0;
`ifdef PED_QUEUE_EN
    w_pend_nxt  = r_pend;
    if ((r_state != ST_IDLE) && w_btn_rise) begin
      w_pend_nxt = 1'b1;
    end
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_btn_rise) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_p         = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = ST_PARADE;
        w_pcnt_nxt  = c_parade;
      end
      ST_PARADE: begin
        w_busy     = 1'b1;
        w_pcnt_nxt = r_pcnt - c_one;
        if (r_pcnt == c_one) begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_r    = 1'b1;
        w_busy = 1'b1;
`ifdef PED_QUEUE_EN
        // A queued press, or one arriving now, chains straight into a new request
        if (r_pend || w_btn_rise) begin
          w_state_nxt = ST_REQ;
          w_pend_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.o_TA   = w_traffic[0];
  assign bus.o_TB   = w_traffic[1];
  assign bus.o_P    = w_p;
  assign bus.o_R    = w_r;
  assign bus.o_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_traffic_sensor_cond.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_traffic_sensor_cond                                                 |
// | Directed and random stimulus against an event-time reference model.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_traffic_sensor_cond;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int PAR  = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  traffic_sensor_cond_if bus ();

  traffic_sensor_cond #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .PARADE_CYCLES(PAR),
    .CNT_W        (8)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: outputs derived from event times (fall time, parade start)
  int m_n;
  bit m_s1[3];
  bit m_s2[3];
  bit m_deb[3];
  int m_run[3];
  int m_fall[3];
  int m_pstart;
  bit m_pend;
  bit m_btn_q;

  function automatic bit m_busy(input int k);
    return (k >= m_pstart) && (k - m_pstart <= PAR + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0; m_fall[i] = -1000;
    end
    m_pstart = -1000;
    m_pend   = 0;
    m_btn_q  = 0;
  endtask

  task automatic model_edge();
    bit raw[3];
    bit rise;
    bit busy_n;
    bit rel_n;
    raw[0] = bus.i_sens_a;
    raw[1] = bus.i_sens_b;
    raw[2] = bus.i_ped_btn;
    if (!rstn) begin
      model_reset();
    end else begin
      rise   = m_deb[2] && !m_btn_q;
      busy_n = m_busy(m_n);
      rel_n  = busy_n && (m_n == m_pstart + PAR + 1);
      if (!busy_n) begin
        if (rise) m_pstart = m_n + 1;
      end
`ifdef PED_QUEUE_EN
      else if (rel_n && (m_pend || rise)) begin
        m_pstart = m_n + 1;
        m_pend   = 0;
      end else if (rise) begin
        m_pend = 1;
      end
`endif
      m_btn_q = m_deb[2];
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_deb[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == DEB) begin
          m_deb[i] = !m_deb[i];
          m_run[i] = 0;
          if (!m_deb[i]) m_fall[i] = m_n + 1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
    m_n++;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_TA", bus.o_TA, m_deb[0] || (m_n - m_fall[0] < HOLD));
    chk("model_TB", bus.o_TB, m_deb[1] || (m_n - m_fall[1] < HOLD));
    chk("model_P", bus.o_P, m_n == m_pstart);
    chk("model_R", bus.o_R, m_n == m_pstart + PAR + 1);
    chk("model_busy", bus.o_busy, m_busy(m_n));
    chk("p_r_excl", bus.o_P & bus.o_R, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic settle(input int k);
    repeat (k) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, bus.o_TA | bus.o_TB | bus.o_P | bus.o_R | bus.o_busy, 1'b0);
  endtask

  initial begin
    model_reset();
    m_n = 0;
    bus.i_sens_a = 1; bus.i_sens_b = 1; bus.i_ped_btn = 1;
    rstn = 0;
    @(negedge clk);

    // Reset with all raw inputs high
    repeat (5) begin
      step();
      chk_all_zero("rst_outputs");
    end
    rstn = 1;
    step();
    chk_all_zero("post_rst_outputs");
    bus.i_sens_a = 0; bus.i_sens_b = 0; bus.i_ped_btn = 0;
    settle(60);

    // Debounce latency on A and a rejected 3-cycle glitch on B
    for (int c = 0; c <= 12; c++) begin
      bus.i_sens_a = 1;
      bus.i_sens_b = (c < 3);
      chk("deb_TA", bus.o_TA, c >= 6);
      chk("glitch_TB", bus.o_TB, 1'b0);
      step();
    end

    // Hold after the sensor falls
    for (int c = 0; c <= 20; c++) begin
      bus.i_sens_a = 0;
      chk("hold_TA", bus.o_TA, c < 14);
      step();
    end
    bus.i_sens_a = 1;
    settle(12);

    // Re-rise during the hold keeps TA continuously high
    for (int c = 0; c <= 25; c++) begin
      bus.i_sens_a = (c >= 4);
      chk("rerise_TA", bus.o_TA, 1'b1);
      step();
    end
    bus.i_sens_a = 0;
    settle(30);

    // Single parade, button held 10 cycles
    for (int c = 0; c <= 30; c++) begin
      bus.i_ped_btn = (c < 10);
      chk("p1_P", bus.o_P, c == 7);
      chk("p1_R", bus.o_R, c == 24);
      chk("p1_busy", bus.o_busy, (c >= 7) && (c <= 24));
      step();
    end
    settle(10);

    // Second press during the parade
    for (int c = 0; c <= 50; c++) begin
      bus.i_ped_btn = (c < 6) || ((c >= 12) && (c < 18));
`ifdef PED_QUEUE_EN
      chk("q_P", bus.o_P, (c == 7) || (c == 25));
      chk("q_R", bus.o_R, (c == 24) || (c == 42));
      chk("q_busy", bus.o_busy, (c >= 7) && (c <= 42));
`else
      chk("q_P", bus.o_P, c == 7);
      chk("q_R", bus.o_R, c == 24);
      chk("q_busy", bus.o_busy, (c >= 7) && (c <= 24));
`endif
      step();
    end
    settle(10);

    // Reset mid-parade aborts without a release pulse
    for (int c = 0; c <= 15; c++) begin
      bus.i_ped_btn = (c < 6);
      chk("ab_P", bus.o_P, c == 7);
      chk("ab_busy", bus.o_busy, c >= 7);
      if (c < 15) step();
    end
    rstn = 0;
    step();
    chk("ab_busy_after_rst", bus.o_busy, 1'b0);
    step();
    rstn = 1;
    for (int c = 0; c < 30; c++) begin
      chk("ab_noR", bus.o_R, 1'b0);
      chk("ab_idle", bus.o_busy, 1'b0);
      step();
    end
    for (int c = 0; c <= 26; c++) begin
      bus.i_ped_btn = (c < 6);
      chk("ab2_P", bus.o_P, c == 7);
      chk("ab2_R", bus.o_R, c == 24);
      step();
    end

    // Random inputs with occasional resets, checked against the model
    repeat (4000) begin
      if ($urandom_range(0, 9) == 0) bus.i_sens_a = ~bus.i_sens_a;
      if ($urandom_range(0, 9) == 0) bus.i_sens_b = ~bus.i_sens_b;
      if ($urandom_range(0, 7) == 0) bus.i_ped_btn = ~bus.i_ped_btn;
      rstn = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
